// File: rtl/card_shuffler.sv
// Memory-match deck: fills 36 cards in pair order on start, then Fisher-Yates shuffles them in place
// using a free-running LFSR. Two combinational read ports serve the comparison logic.
module card_shuffler #(
   parameter int          NUM_CARDS = 36,
   parameter int          ADDR_W    = 6,
   parameter int          CARD_W    = 5,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] card1Loc,
   input  logic [ADDR_W-1:0] card2Loc,
   output logic [CARD_W-1:0] cardData1,
   output logic [CARD_W-1:0] cardData2,
   output logic              busy,
   output logic              ready
);

   typedef enum logic [2:0] {IDLE, FILL, PICK, SWAP, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CARDS - 1);
   localparam logic [ADDR_W:0]   NUM_EXT  = (ADDR_W + 1)'(NUM_CARDS);

   state_t            state;
   logic [CARD_W-1:0] deck [NUM_CARDS];
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] j;
   logic [15:0]       lfsr;
   logic              start_q;
   logic              start_req;
   logic [ADDR_W-1:0] rnd;

   assign rnd       = lfsr[ADDR_W-1:0];
   // A held start only counts once: act on the rising edge.
   assign start_req = start & ~start_q;

   always_comb begin
      cardData1 = '1;
      cardData2 = '1;
      if ({1'b0, card1Loc} < NUM_EXT) cardData1 = deck[card1Loc];
      if ({1'b0, card2Loc} < NUM_EXT) cardData2 = deck[card2Loc];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         ready   <= 1'b0;
         idx     <= '0;
         j       <= '0;
         lfsr    <= LFSR_SEED;
         start_q <= 1'b0;
         for (int i = 0; i < NUM_CARDS; i++) deck[i] <= '0;
      end else begin
         // Taps 16,14,13,11; stepping every cycle lets the press time seed the shuffle.
         lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         start_q <= start;
         case (state)
            IDLE, DONE: begin
               if (start_req) begin
                  state <= FILL;
                  idx   <= '0;
                  busy  <= 1'b1;
                  ready <= 1'b0;
               end
            end
            FILL: begin
               deck[idx] <= CARD_W'(idx >> 1);
               if (idx == LAST_IDX) state <= PICK;
               else                 idx   <= idx + ADDR_W'(1);
            end
            PICK: begin
               // Rejection sampling keeps j uniform over 0..idx without a modulo.
               if (rnd <= idx) begin
                  j     <= rnd;
                  state <= SWAP;
               end
            end
            SWAP: begin
               deck[idx] <= deck[j];
               deck[j]   <= deck[idx];
               if (idx == ADDR_W'(1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  ready <= 1'b1;
               end else begin
                  idx   <= idx - ADDR_W'(1);
                  state <= PICK;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_card_shuffler.sv
// Randomised bench for card_shuffler: a Fisher-Yates reference model predicts each shuffled deck and
// its completion time; a monitor checks the deck whenever ready rises.
module tb_card_shuffler;

   localparam int          N    = 36;
   localparam int          AW   = 6;
   localparam int          CW   = 5;
   localparam logic [15:0] SEED = 16'hACE1;

   typedef logic [N*CW-1:0] deck_vec_t;
   typedef struct packed {
      int        start_cyc;
      int        edges;
      deck_vec_t deck;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] card1Loc, card2Loc;
   logic [CW-1:0] cardData1, cardData2;
   logic          busy, ready;

   logic [AW-1:0] stim_loc1 = '0, stim_loc2 = '0;
   logic [AW-1:0] mon_loc1 = '0, mon_loc2 = '0;
   logic          mon_active = 1'b0;

   int        vectors = 0;
   int        miscompares = 0;
   int        cyc = 0;
   int        mon_done = 0;
   int        target = 0;
   logic [15:0] m_lfsr = SEED;
   exp_t      sb[$];
   exp_t      last_exp;

   assign card1Loc = mon_active ? mon_loc1 : stim_loc1;
   assign card2Loc = mon_active ? mon_loc2 : stim_loc2;

   card_shuffler #(.NUM_CARDS(N), .ADDR_W(AW), .CARD_W(CW), .LFSR_SEED(SEED)) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .card1Loc(card1Loc), .card2Loc(card2Loc),
      .cardData1(cardData1), .cardData2(cardData2),
      .busy(busy), .ready(ready)
   );

   always #50 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   // Free-running reference copy of the random source, known value at any start press.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) m_lfsr <= SEED;
      else          m_lfsr <= lfsr_step(m_lfsr);
   end

   // Whole shuffle from the random-source value seen just before the start edge.
   function automatic void model(input logic [15:0] a, output deck_vec_t d, output int edges);
      int          dk[N];
      logic [15:0] l;
      int          jj, tmp;
      for (int i = 0; i < N; i++) dk[i] = i / 2;
      l = a;
      repeat (N + 1) l = lfsr_step(l);   // start edge + one fill edge per card
      edges = N + 1;
      for (int k = N - 1; k >= 1; k--) begin
         while (int'(l[AW-1:0]) > k) begin
            l = lfsr_step(l);
            edges++;
         end
         jj = int'(l[AW-1:0]);
         l = lfsr_step(lfsr_step(l));     // accepting pick edge + swap edge
         edges += 2;
         tmp = dk[k]; dk[k] = dk[jj]; dk[jj] = tmp;
      end
      for (int i = 0; i < N; i++) d[i*CW +: CW] = CW'(dk[i]);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // busy and ready must never be high together.
   always @(negedge clock) begin
      if (reset_n) begin
         vectors++;
         assert (!(busy && ready)) else begin
            miscompares++;
            $display("FAIL busy_ready_excl: got busy=%0b ready=%0b, expected not both", busy, ready);
         end
      end
   end

   // Monitor: on each rising ready, pop the prediction and read back the whole deck.
   logic      rdy_q = 1'b0;
   logic      rdy_now;
   exp_t      e_mon;
   logic [CW-1:0] got [N];
   logic [CW-1:0] prev [N];
   int        cnt [N/2];
   int        nshuf = 0;
   logic      differs;

   always @(negedge clock) begin
      rdy_now = ready;
      if (reset_n && rdy_now && !rdy_q) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_ready: got ready=1, expected no pending shuffle");
         end else begin
            e_mon = sb.pop_front();
            check("latency", 32'(cyc - e_mon.start_cyc), 32'(e_mon.edges));
            mon_active = 1'b1;
            for (int k = 0; k < N / 2; k++) begin
               mon_loc1 = AW'(2 * k);
               mon_loc2 = AW'(2 * k + 1);
               #1;
               got[2*k]   = cardData1;
               got[2*k+1] = cardData2;
            end
            mon_active = 1'b0;
            for (int i = 0; i < N; i++)
               check($sformatf("deck[%0d]", i), 32'(got[i]), 32'(e_mon.deck[i*CW +: CW]));
            for (int p = 0; p < N / 2; p++) cnt[p] = 0;
            for (int i = 0; i < N; i++) if (int'(got[i]) < N / 2) cnt[got[i]]++;
            for (int p = 0; p < N / 2; p++) check($sformatf("pair_count[%0d]", p), 32'(cnt[p]), 32'd2);
            if (nshuf > 0) begin
               differs = 1'b0;
               for (int i = 0; i < N; i++) if (got[i] != prev[i]) differs = 1'b1;
               check("reshuffle_differs", 32'(differs), 32'd1);
            end
            for (int i = 0; i < N; i++) prev[i] = got[i];
            nshuf++;
            $display("shuffle %0d complete: latency %0d cycles, deck[0..3]=%0d %0d %0d %0d",
                     nshuf, cyc - e_mon.start_cyc, got[0], got[1], got[2], got[3]);
            mon_done++;
         end
      end
      rdy_q = rdy_now;
   end

   task automatic wait_done(input int tgt);
      int c = 0;
      while (mon_done < tgt && c < 20000) begin
         @(negedge clock);
         c++;
      end
      check("shuffle_completed", 32'(mon_done), 32'(tgt));
   endtask

   task automatic run_shuffle(input bit check_fill, input bit stray, input int hold);
      exp_t e;
      repeat ($urandom_range(0, 40)) @(negedge clock);
      e.start_cyc = cyc;
      model(m_lfsr, e.deck, e.edges);
      sb.push_back(e);
      last_exp = e;
      start = 1'b1;
      @(negedge clock);
      check("busy_after_start", 32'(busy), 32'd1);
      check("ready_after_start", 32'(ready), 32'd0);
      for (int c = 1; c < N + 1; c++) begin
         start = (c < hold) || (stray && (c == 5 || c == 20));
         @(negedge clock);
      end
      start = 1'b0;
      check("busy_after_fill", 32'(busy), 32'd1);
      if (check_fill) begin
         for (int k = 0; k < N / 2; k++) begin
            stim_loc1 = AW'(2 * k);
            stim_loc2 = AW'(2 * k + 1);
            #1;
            check($sformatf("fill[%0d]", 2 * k), 32'(cardData1), 32'(k));
            check($sformatf("fill[%0d]", 2 * k + 1), 32'(cardData2), 32'(k));
         end
      end
      target++;
      wait_done(target);
   endtask

   task automatic read_checks();
      int l, l2;
      l  = $urandom_range(0, N - 1);
      l2 = $urandom_range(N, 63);
      stim_loc1 = AW'(l);
      stim_loc2 = AW'(l);
      #1;
      check("same_loc_equal", 32'(cardData1), 32'(cardData2));
      check("same_loc_value", 32'(cardData1), 32'(last_exp.deck[l*CW +: CW]));
      stim_loc1 = AW'(l2);
      #1;
      check("oob_read", 32'(cardData1), 32'h1F);
      check("port2_value", 32'(cardData2), 32'(last_exp.deck[l*CW +: CW]));
   endtask

   task automatic abort_shuffle();
      repeat ($urandom_range(1, 10)) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (N + $urandom_range(5, 40)) @(negedge clock);
      #10 reset_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(ready), 32'd0);
      for (int k = 0; k < N / 2; k++) begin
         stim_loc1 = AW'(2 * k);
         stim_loc2 = AW'(2 * k + 1);
         #1;
         check($sformatf("abort_clear[%0d]", 2 * k), 32'(cardData1), 32'd0);
         check($sformatf("abort_clear[%0d]", 2 * k + 1), 32'(cardData2), 32'd0);
      end
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clock);
      check("reset_ready", 32'(ready), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      for (int k = 0; k < N / 2; k++) begin
         stim_loc1 = AW'(2 * k);
         stim_loc2 = AW'(2 * k + 1);
         #1;
         check($sformatf("reset_deck[%0d]", 2 * k), 32'(cardData1), 32'd0);
         check($sformatf("reset_deck[%0d]", 2 * k + 1), 32'(cardData2), 32'd0);
      end
      stim_loc1 = AW'(40);
      #1;
      check("reset_oob", 32'(cardData1), 32'h1F);
      @(negedge clock);
      reset_n = 1'b1;

      run_shuffle(1'b1, 1'b0, 1);
      read_checks();
      run_shuffle(1'b0, 1'b0, $urandom_range(2, 4));
      read_checks();
      run_shuffle(1'b0, 1'b1, 1);
      abort_shuffle();
      run_shuffle(1'b1, 1'b0, 1);
      read_checks();

      repeat (5) @(negedge clock);
      check("queue_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
